// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch controller.
//   fetch_state_t     : sequencing states of the fetch controller
//   RESET_PC_DEFAULT  : default boot address
//   INSTR_NOP_DEFAULT : default word shown to decode when nothing is held
//   PC_STEP           : byte distance between consecutive instructions
//   word_align()      : clears the two byte-offset bits of an address
//   pc_advance()      : next sequential fetch address (modulo 2^32)
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        FETCH   = 2'd1,
        SKID    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP           = 32'd4;

    // Instructions are word aligned, so redirect targets lose their low bits.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    // Plain 32-bit add: 32'hFFFF_FFFC advances to 32'h0000_0000.
    function automatic logic [31:0] pc_advance(input logic [31:0] addr);
        return addr + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched word and its address.
// It parks a memory response that arrived while decode was stalled.
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   load           : capture load_instr/load_addr and mark the entry full
//   unload         : entry has been handed on; mark it empty
//   clear          : drop the entry (redirect); highest priority
//   valid          : entry is full
//   instr, addr    : held word and its address (registered)
module fetch_skid_buf
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] EMPTY_INSTR = INSTR_NOP_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        unload,
    input  logic        clear,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_addr,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] addr
);

    logic        valid_r;
    logic [31:0] instr_r;
    logic [31:0] addr_r;

    // Entry storage: clear beats load beats unload; data is kept when emptied.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_r <= 1'b0;
            instr_r <= EMPTY_INSTR;
            addr_r  <= 32'h0000_0000;
        end else if (clear) begin
            valid_r <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
            instr_r <= load_instr;
            addr_r  <= load_addr;
        end else if (unload) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign valid = valid_r;
    assign instr = instr_r;
    assign addr  = addr_r;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer for a variable-latency instruction memory.
// Issues one request at a time, hands words to decode through a
// valid/stall interface, redirects on jumps and parks one word in a skid
// buffer when decode back-pressures.
//   clock, reset              : rising-edge clock, synchronous active-high reset
//   jump_flg, jump_target     : redirect request (highest priority) and address
//   stall                     : decode cannot take if_* this cycle
//   imem_req, imem_addr       : memory request (req decoded from state)
//   imem_ready, imem_rdata    : memory response, may come in the request cycle
//   if_valid, if_instr, if_addr : word presented to decode
//   pc                        : next address to fetch
module fetch_ctrl
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] INSTR_NOP = INSTR_NOP_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        jump_flg,
    input  logic [31:0] jump_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_addr,
    output logic [31:0] pc
);

    fetch_state_t state_r, state_nxt_s;
    logic [31:0]  pc_r, pc_nxt_s;
    logic [31:0]  imem_addr_r, imem_addr_nxt_s;
    logic         if_valid_r, if_valid_nxt_s;
    logic [31:0]  if_instr_r, if_instr_nxt_s;
    logic [31:0]  if_addr_r, if_addr_nxt_s;

    logic         skid_load_s;
    logic         skid_unload_s;
    logic         skid_clear_s;
    logic         skid_valid_s;
    logic [31:0]  skid_instr_s;
    logic [31:0]  skid_addr_s;

    logic         slot_free_s;
    logic [31:0]  target_s;
    logic [31:0]  pc_inc_s;

    assign slot_free_s = !if_valid_r || !stall;
    assign target_s    = word_align(jump_target);
    assign pc_inc_s    = pc_advance(pc_r);

    // A request is outstanding only while fetching or draining a stale response.
    assign imem_req = (state_r == FETCH) || (state_r == DISCARD);

    fetch_skid_buf #(
        .EMPTY_INSTR (INSTR_NOP)
    ) u_skid (
        .clock      (clock),
        .reset      (reset),
        .load       (skid_load_s),
        .unload     (skid_unload_s),
        .clear      (skid_clear_s),
        .load_instr (imem_rdata),
        .load_addr  (imem_addr_r),
        .valid      (skid_valid_s),
        .instr      (skid_instr_s),
        .addr       (skid_addr_s)
    );

    // Next-state and next-output decode for the fetch sequencer.
    always_comb begin
        state_nxt_s     = state_r;
        pc_nxt_s        = pc_r;
        imem_addr_nxt_s = imem_addr_r;
        if_addr_nxt_s   = if_addr_r;
        skid_load_s     = 1'b0;
        skid_unload_s   = 1'b0;
        skid_clear_s    = 1'b0;

        // Decode takes the presented word; capture paths below may refill it.
        if (if_valid_r && !stall) begin
            if_valid_nxt_s = 1'b0;
            if_instr_nxt_s = INSTR_NOP;
        end else begin
            if_valid_nxt_s = if_valid_r;
            if_instr_nxt_s = if_instr_r;
        end

        case (state_r)
            BOOT: begin
                // The request address must already equal pc on entry to FETCH.
                if (jump_flg) begin
                    pc_nxt_s        = target_s;
                    imem_addr_nxt_s = target_s;
                end else begin
                    imem_addr_nxt_s = pc_r;
                end
                state_nxt_s = FETCH;
            end

            FETCH: begin
                if (jump_flg) begin
                    pc_nxt_s       = target_s;
                    if_valid_nxt_s = 1'b0;
                    if_instr_nxt_s = INSTR_NOP;
                    if (imem_ready) begin
                        // Response is for the old stream: drop it, restart at target.
                        imem_addr_nxt_s = target_s;
                        state_nxt_s     = FETCH;
                    end else begin
                        // Address must stay put until the stale response drains.
                        state_nxt_s = DISCARD;
                    end
                end else if (imem_ready) begin
                    pc_nxt_s        = pc_inc_s;
                    imem_addr_nxt_s = pc_inc_s;
                    if (slot_free_s) begin
                        if_valid_nxt_s = 1'b1;
                        if_instr_nxt_s = imem_rdata;
                        if_addr_nxt_s  = imem_addr_r;
                        state_nxt_s    = FETCH;
                    end else begin
                        skid_load_s = 1'b1;
                        state_nxt_s = SKID;
                    end
                end else begin
                    state_nxt_s = FETCH;
                end
            end

            SKID: begin
                if (jump_flg) begin
                    pc_nxt_s        = target_s;
                    imem_addr_nxt_s = target_s;
                    if_valid_nxt_s  = 1'b0;
                    if_instr_nxt_s  = INSTR_NOP;
                    skid_clear_s    = 1'b1;
                    state_nxt_s     = FETCH;
                end else if (!stall || !skid_valid_s) begin
                    // Decode consumes the current word this cycle; the parked one replaces it.
                    if_valid_nxt_s = skid_valid_s;
                    if_instr_nxt_s = skid_valid_s ? skid_instr_s : INSTR_NOP;
                    if_addr_nxt_s  = skid_addr_s;
                    skid_unload_s  = 1'b1;
                    state_nxt_s    = FETCH;
                end else begin
                    state_nxt_s = SKID;
                end
            end

            DISCARD: begin
                // Later jumps only move pc; the request in flight is still the old one.
                if (jump_flg) begin
                    pc_nxt_s       = target_s;
                    if_valid_nxt_s = 1'b0;
                    if_instr_nxt_s = INSTR_NOP;
                end else begin
                    pc_nxt_s = pc_r;
                end
                if (imem_ready) begin
                    imem_addr_nxt_s = jump_flg ? target_s : pc_r;
                    state_nxt_s     = FETCH;
                end else begin
                    state_nxt_s = DISCARD;
                end
            end

            default: begin
                state_nxt_s = BOOT;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= BOOT;
            pc_r        <= RESET_PC;
            imem_addr_r <= RESET_PC;
            if_valid_r  <= 1'b0;
            if_instr_r  <= INSTR_NOP;
            if_addr_r   <= 32'h0000_0000;
        end else begin
            state_r     <= state_nxt_s;
            pc_r        <= pc_nxt_s;
            imem_addr_r <= imem_addr_nxt_s;
            if_valid_r  <= if_valid_nxt_s;
            if_instr_r  <= if_instr_nxt_s;
            if_addr_r   <= if_addr_nxt_s;
        end
    end

    assign imem_addr = imem_addr_r;
    assign if_valid  = if_valid_r;
    assign if_instr  = if_instr_r;
    assign if_addr   = if_addr_r;
    assign pc        = pc_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios with literal
// expectations, then randomized stimulus against a queue-based model.
module tb_fetch_ctrl;

    localparam logic [31:0] NOP     = 32'h0000_0000;
    localparam logic [31:0] MAIN_RP = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, jump_flg, stall, imem_ready;
    logic [31:0] jump_target, imem_rdata;
    logic        imem_req, if_valid;
    logic [31:0] imem_addr, if_instr, if_addr, pc;

    logic        w_imem_req, w_if_valid;
    logic [31:0] w_imem_addr, w_if_instr, w_if_addr, w_pc;

    fetch_ctrl #(.RESET_PC(MAIN_RP), .INSTR_NOP(NOP)) u_dut (
        .clock(clock), .reset(reset), .jump_flg(jump_flg), .jump_target(jump_target),
        .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .if_valid(if_valid),
        .if_instr(if_instr), .if_addr(if_addr), .pc(pc)
    );

    // Zero-wait memory, never stalled, booting at the top of the address space.
    fetch_ctrl #(.RESET_PC(WRAP_PC), .INSTR_NOP(NOP)) u_wrap (
        .clock(clock), .reset(reset), .jump_flg(1'b0), .jump_target(32'h0000_0000),
        .stall(1'b0), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_ready(1'b1), .imem_rdata(w_imem_addr ^ 32'hA5A5_0000), .if_valid(w_if_valid),
        .if_instr(w_if_instr), .if_addr(w_if_addr), .pc(w_pc)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    int wait_cnt  = 0;
    int cur_lat   = 0;
    int lat_fixed = 0;
    bit data_xor  = 1'b1;

    function automatic int pick_lat();
        if (lat_fixed >= 0) return lat_fixed;
        else return int'($urandom_range(0, 3));
    endfunction

    task automatic drive_mem();
        if (imem_req) begin
            imem_ready = (wait_cnt >= cur_lat);
            wait_cnt++;
        end else begin
            imem_ready = 1'b0;
            wait_cnt   = 0;
        end
        imem_rdata = data_xor ? (imem_addr ^ 32'hA5A5_0000) : $urandom();
    endtask

    // ---------------- behavioural model ----------------
    // mq holds the words owed to decode in order: mq[0] is on if_*, mq[1] is parked.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
    } word_t;

    word_t       mq[$];
    bit          m_boot = 1'b1;
    bit          m_disc = 1'b0;
    logic [31:0] m_pc   = MAIN_RP;
    logic [31:0] m_addr = MAIN_RP;

    // Memory is asked only when a word can be accepted or a stale one is draining.
    function automatic bit m_req();
        return !m_boot && (m_disc || mq.size() < 2);
    endfunction

    task automatic model_update();
        bit          req;
        logic [31:0] tgt;
        word_t       w;
        req = m_req();
        tgt = jump_target & 32'hFFFF_FFFC;
        if (reset) begin
            m_boot = 1'b1;
            m_disc = 1'b0;
            m_pc   = MAIN_RP;
            m_addr = MAIN_RP;
            mq.delete();
        end else if (m_boot) begin
            m_boot = 1'b0;
            if (jump_flg) m_pc = tgt;
            m_addr = m_pc;
        end else if (jump_flg) begin
            mq.delete();
            m_pc = tgt;
            if (m_disc) begin
                if (imem_ready) begin
                    m_disc = 1'b0;
                    m_addr = m_pc;
                end
            end else if (req) begin
                if (imem_ready) m_addr = m_pc;
                else m_disc = 1'b1;
            end else begin
                m_addr = m_pc;
            end
        end else begin
            if (mq.size() > 0 && !stall) void'(mq.pop_front());
            if (m_disc) begin
                if (imem_ready) begin
                    m_disc = 1'b0;
                    m_addr = m_pc;
                end
            end else if (req && imem_ready) begin
                w.instr = imem_rdata;
                w.addr  = m_addr;
                mq.push_back(w);
                m_pc   = m_pc + 32'd4;
                m_addr = m_pc;
            end
        end
        if (reset || imem_ready) begin
            wait_cnt = 0;
            cur_lat  = pick_lat();
        end
    endtask

    task automatic compare_all();
        chk1("imem_req", imem_req, m_req());
        chk("imem_addr", imem_addr, m_addr);
        chk("pc", pc, m_pc);
        chk1("if_valid", if_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            chk("if_instr", if_instr, mq[0].instr);
            chk("if_addr", if_addr, mq[0].addr);
        end else begin
            chk("if_instr_nop", if_instr, NOP);
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_update();
        @(negedge clock);
        compare_all();
        drive_mem();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        bit saw20;
        int vcount;

        reset = 1'b1; jump_flg = 1'b0; jump_target = 32'h0; stall = 1'b0;
        imem_ready = 1'b0; imem_rdata = 32'h0;

        // T1: zero-wait stream from reset, plus wrap instance.
        lat_fixed = 0; data_xor = 1'b1;
        do_reset(2);
        chk1("t1 rst imem_req", imem_req, 1'b0);
        chk("t1 rst pc", pc, 32'h0000_0000);
        chk("t1 rst imem_addr", imem_addr, 32'h0000_0000);
        chk1("t1 rst if_valid", if_valid, 1'b0);
        chk("t1 rst if_instr", if_instr, NOP);
        chk("t1 rst if_addr", if_addr, 32'h0000_0000);
        chk("t1 rst wrap pc", w_pc, WRAP_PC);
        step();
        chk1("t1 boot if_valid", if_valid, 1'b0);
        chk1("t1 boot then req", imem_req, 1'b1);
        step();
        chk1("t1 first valid", if_valid, 1'b1);
        chk("t1 addr0", if_addr, 32'h0000_0000);
        chk("t1 instr0", if_instr, 32'hA5A5_0000);
        chk("t1 wrap addr", w_if_addr, 32'hFFFF_FFFC);
        chk("t1 wrap instr", w_if_instr, 32'h5A5A_FFFC);
        chk("t1 wrap pc", w_pc, 32'h0000_0000);
        step();
        chk("t1 addr4", if_addr, 32'h0000_0004);
        chk("t1 wrap addr0", w_if_addr, 32'h0000_0000);
        chk1("t1 wrap valid", w_if_valid, 1'b1);
        chk("t1 wrap pc4", w_pc, 32'h0000_0004);
        chk1("t1 wrap req", w_imem_req, 1'b1);
        chk("t1 wrap imem_addr", w_imem_addr, 32'h0000_0004);
        step();
        chk("t1 addr8", if_addr, 32'h0000_0008);

        // T2: 3-cycle latency, one word every third cycle.
        lat_fixed = 2;
        do_reset(1);
        vcount = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (if_valid) vcount++;
            if (i == 2) chk("t2 addr held", imem_addr, 32'h0000_0000);
        end
        chk("t2 valid pulses", 32'(vcount), 32'd3);
        chk("t2 pc", pc, 32'h0000_000C);

        // T3: stall as the 0x10 response returns -> skid.
        lat_fixed = 0;
        do_reset(1);
        repeat (5) step();
        stall = 1'b1;
        step();
        chk1("t3 skid req", imem_req, 1'b0);
        chk("t3 skid if_addr", if_addr, 32'h0000_000C);
        chk1("t3 skid valid", if_valid, 1'b1);
        step();
        chk1("t3 skid hold req", imem_req, 1'b0);
        chk("t3 skid hold addr", if_addr, 32'h0000_000C);
        stall = 1'b0;
        step();
        chk("t3 unskid addr", if_addr, 32'h0000_0010);
        chk("t3 resume imem_addr", imem_addr, 32'h0000_0014);
        chk1("t3 resume req", imem_req, 1'b1);
        step();
        chk("t3 next addr", if_addr, 32'h0000_0014);

        // T4: jump while the 0x20 request waits on 2-cycle memory.
        lat_fixed = 1;
        do_reset(1);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (imem_req && imem_addr == 32'h0000_0020 && !imem_ready) found = 1'b1;
        end
        chk1("t4 reached 0x20", found, 1'b1);
        jump_flg = 1'b1; jump_target = 32'h0000_0400;
        step();
        jump_flg = 1'b0;
        chk1("t4 flush", if_valid, 1'b0);
        chk("t4 addr held", imem_addr, 32'h0000_0020);
        chk("t4 pc", pc, 32'h0000_0400);
        chk1("t4 discard req", imem_req, 1'b1);
        step();
        chk("t4 redirect addr", imem_addr, 32'h0000_0400);
        chk1("t4 still empty", if_valid, 1'b0);
        saw20 = 1'b0;
        repeat (6) begin
            step();
            if (if_valid && if_addr == 32'h0000_0020) saw20 = 1'b1;
        end
        chk1("t4 0x20 dropped", saw20, 1'b0);

        // T5: misaligned jump while stalled with a valid word.
        lat_fixed = 0;
        do_reset(1);
        repeat (3) step();
        stall = 1'b1; jump_flg = 1'b1; jump_target = 32'h0000_0103;
        step();
        jump_flg = 1'b0;
        chk1("t5 flush", if_valid, 1'b0);
        chk("t5 pc", pc, 32'h0000_0100);
        chk("t5 imem_addr", imem_addr, 32'h0000_0100);
        chk1("t5 req", imem_req, 1'b1);
        step();
        chk("t5 capture", if_addr, 32'h0000_0100);
        chk1("t5 valid", if_valid, 1'b1);
        stall = 1'b0;

        // T6: reset in the middle of a long wait, then wrap sequence again.
        lat_fixed = 3;
        do_reset(1);
        repeat (3) step();
        reset = 1'b1;
        step();
        chk("t6 pc", pc, 32'h0000_0000);
        chk("t6 imem_addr", imem_addr, 32'h0000_0000);
        chk1("t6 req", imem_req, 1'b0);
        chk1("t6 valid", if_valid, 1'b0);
        chk("t6 instr", if_instr, NOP);
        chk("t6 wrap imem_addr", w_imem_addr, WRAP_PC);
        chk1("t6 wrap valid", w_if_valid, 1'b0);
        reset = 1'b0;
        step(); step();
        chk("t6 wrap first", w_if_addr, 32'hFFFF_FFFC);
        step();
        chk("t6 wrap second", w_if_addr, 32'h0000_0000);

        // Random phase: random latency, stall, jumps and occasional resets.
        lat_fixed = -1; data_xor = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            reset    = ($urandom_range(0, 199) == 0);
            jump_flg = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0)
                jump_target = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else
                jump_target = $urandom();
            stall = ($urandom_range(0, 9) < 3);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
